// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty fetch/sequencing stage.
package bitty_pkg;

  localparam int unsigned INSTR_W = 16;

  // Encoding that stops sequencing; it is never handed to the core.
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/bitty_instr_mem.sv
// Instruction memory: DEPTH x INSTR_W, one synchronous write port and one
// synchronous read port with a single cycle of read latency. Reads beyond
// DEPTH return HALT_WORD; writes beyond DEPTH are dropped. The read-data
// register only updates when re_i is high, so it doubles as the stage's
// instruction holding register.
module bitty_instr_mem
  import bitty_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          DEPTH     = 256,
  parameter logic [INSTR_W-1:0]   HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rdata_q;
  logic               waddr_ok_c;
  logic               raddr_ok_c;

  assign waddr_ok_c = 32'(waddr_i) < DEPTH;
  assign raddr_ok_c = 32'(raddr_i) < DEPTH;

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i && waddr_ok_c) begin
      mem_q[waddr_i[MEM_AW-1:0]] <= wdata_i;
    end
  end

  // Registered read, cleared by reset so the instruction output starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= raddr_ok_c ? mem_q[raddr_i[MEM_AW-1:0]] : HALT_WORD;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitty_fetch_unit.sv
// Fetch and sequencing stage in front of bitty_core: holds the PC, fetches one
// word at a time from bitty_instr_mem, pulses run for one cycle and waits for
// the core's done before advancing. Stops on HALT_WORD.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT cycles)
// that sets a sticky error and halts; without it error is constant 0.
module bitty_fetch_unit
  import bitty_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 8,
  parameter int unsigned        DEPTH     = 256,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned        TIMEOUT   = 64
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_wdata,
  input  logic               done,
  output logic [INSTR_W-1:0] instruction,
  output logic               run,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic              mem_we_c;
  logic              mem_re_c;
  logic              timeout_c;

  // Loads are only honoured while the unit is parked.
  assign mem_we_c = mem_we && ((state_q == ST_IDLE) || (state_q == ST_HALT));
  assign mem_re_c = (state_q == ST_FETCH);

  bitty_instr_mem #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .HALT_WORD (HALT_WORD)
  ) u_imem (
    .clk     (clk),
    .rst_n   (reset),
    .we_i    (mem_we_c),
    .waddr_i (mem_addr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re_c),
    .raddr_i (pc_q),
    .rdata_o (instruction)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // WAIT-cycle count: zero on entry to WAIT, +1 for every cycle spent there.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_c = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state, PC and flag logic; done takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = (instruction == HALT_WORD) ? ST_HALT : ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          state_d = ST_FETCH;
          pc_d    = pc_q + ADDR_W'(1);
        end else if (timeout_c) begin
          state_d = ST_HALT;
          error_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d   = (state_d == ST_FETCH) || (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    halted_d = (state_d == ST_HALT);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // run is a decode of two registers: the ISSUE state and the fetched word.
  assign run    = (state_q == ST_ISSUE) && (instruction != HALT_WORD);
  assign pc     = pc_q;
  assign busy   = busy_q;
  assign halted = halted_q;
  assign error  = error_q;

endmodule
